obi_wb_bridge: RTL and testbench
================================

# obi_wb_bridge

Protocol bridge between the zero-riscy core's OBI-style data port (req/gnt/rvalid) and the single-master Wishbone classic port on the Controller's data-memory bus. It accepts one core request at a time, runs one Wishbone cycle for it and returns exactly one rvalid response, for both reads and writes. It carries byte enables through as `sel` and maps bus errors onto the core's err input. It replaces the ad-hoc ack/data registering in the processorci top, so each core port sees a protocol-correct OBI slave.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, bus-cycle timeout limit; used only when BRIDGE_TIMEOUT_EN is defined

Ports:
- clk_core  in  1  core clock; the only clock
- rst_core  in  1  reset; asynchronous, active-high
- req_i  in  1  core request
- gnt_o  out  1  request accepted
- addr_i  in  ADDR_WIDTH  byte address
- we_i  in  1  1 = write
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, one pulse per granted request
- rdata_o  out  DATA_WIDTH  read data; valid with rvalid_o
- err_o  out  1  error flag; valid with rvalid_o
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  DATA_WIDTH/8  byte selects
- wb_addr_o  out  ADDR_WIDTH  word-aligned address
- wb_data_o  out  DATA_WIDTH  write data
- wb_data_i  in  DATA_WIDTH  read data
- wb_ack_i  in  1  transfer acknowledge
- wb_err_i  in  1  transfer error

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - gnt_o = req_i; combinational and asserted only in IDLE.
  - On req_i: latch addr/we/be/wdata and go to BUS.
- BUS:
  - wb_cyc_o = wb_stb_o = 1. All Wishbone outputs are driven from latched registers.
  - wb_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - wb_sel_o = latched be; wb_data_o = latched wdata.
  - On wb_ack_i: capture wb_data_i (reads only; writes capture 0), set err = 0, go to RESP.
  - On wb_err_i: capture rdata = 0, set err = 1, go to RESP.
  - If wb_ack_i and wb_err_i arrive together, err wins.
- RESP: rvalid_o = 1 for exactly one cycle with registered rdata_o/err_o, then return to IDLE.
- Writes produce rvalid_o as well; rdata_o = 0 for writes.
- rdata_o/err_o hold their last values outside RESP.
- wb_ack_i/wb_err_i outside BUS are ignored.
- Reset values:
  - FSM returns to IDLE immediately (asynchronous).
  - All wb_* outputs, rvalid_o, err_o and rdata_o are 0.
  - gnt_o follows req_i once in IDLE.
  - A transaction in flight at reset is dropped with no rvalid.

## Timing
- Request granted in cycle T (req_i && IDLE) → wb_cyc_o high from T+1.
- ack sampled high at cycle A → wb_cyc_o low at A+1; rvalid_o high during A+1 only.
- Earliest next gnt_o is A+2.
- Zero-wait slave (ack in T+1): gnt at T, rvalid at T+2, next gnt at T+3; one transfer per 3 cycles.
- wb_cyc_o stays continuously high across wait states; stb is never deasserted mid-cycle.
- Address, data and sel are stable for the whole BUS state.

## Configuration
- Macro: BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments every BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES, the bridge drops wb_cyc_o, goes to RESP and returns err_o = 1, rdata_o = 0.
  - An ack arriving on the same cycle the limit is reached is honoured (no error).
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter logic exists and BUS waits indefinitely for ack/err.

## Structure
- Package processorci_bridge_pkg holds:
  - the FSM state enum (bridge_state_t: IDLE, BUS, RESP)
  - the default width localparams
  - the default timeout constant
- One sub-module, wb_timeout_counter (clear, enable, expired output, TIMEOUT_CYCLES parameter), instantiated only under BRIDGE_TIMEOUT_EN.
- The top file instantiates one bridge per core port (instruction and data); the instruction instance ties we_i = 0 and be_i = 4'hF.

## Test plan
- Read with ack 1 cycle after cyc, addr 0x0000_1006, wb_data_i 0xDEADBEEF:
  - wb_addr_o = 0x0000_1004
  - rvalid_o one cycle with rdata_o = 0xDEADBEEF, err_o = 0
  - gnt-to-rvalid latency 2 cycles
- Write addr 0x20, be 4'b0011, wdata 0x12345678, ack after 3 wait states:
  - wb_sel_o = 4'b0011 and wb_data_o stable for 4 cycles
  - exactly one rvalid_o with err_o = 0
- Back-to-back requests with req_i held high:
  - gnt_o every 3rd cycle with a zero-wait slave
  - no gnt_o while in BUS or RESP
- wb_err_i and wb_ack_i asserted together on a read: rvalid_o with err_o = 1, rdata_o = 0.
- rst_core pulsed mid-BUS: wb_cyc_o low in the same cycle; no rvalid_o follows; next request works normally.
- With BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never acks: wb_cyc_o drops after 8 BUS cycles, then rvalid_o with err_o = 1; without the macro, cyc stays high for 1000 cycles.

Source files
------------

// File: rtl/processorci_bridge_pkg.sv
// processorci_bridge_pkg: shared FSM state type and default widths for the OBI-to-Wishbone bridge.
package processorci_bridge_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} bridge_state_t;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/obi_wb_timeout_counter.sv
// wb_timeout_counter: counts stalled Wishbone cycles; exists only when BRIDGE_TIMEOUT_EN is defined.
`ifdef BRIDGE_TIMEOUT_EN
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (enable_i) cnt_q <= cnt_q + 1'b1;
  // Fires on the last permitted stalled cycle so the bus is held exactly TIMEOUT_CYCLES cycles.
  assign expired_o = enable_i && cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule
`endif

// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: OBI (req/gnt/rvalid) slave to Wishbone classic master, one transfer at a time.
// Optional bus-cycle timeout enabled by defining BRIDGE_TIMEOUT_EN.
module obi_wb_bridge
  import processorci_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);
  bridge_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic we_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic err_q;
  logic timeout, done, fail, in_bus;
  assign in_bus = state_q == BUS;
`ifdef BRIDGE_TIMEOUT_EN
  wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_core),
    .rst_i    (rst_core),
    .clear_i  (!in_bus),
    .enable_i (in_bus && !wb_ack_i && !wb_err_i),
    .expired_o(timeout)
  );
`else
  logic timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES[0];
  assign timeout = 1'b0;
`endif
  // Error beats ack; ack beats a timeout landing on the same cycle.
  always_comb begin
    done = wb_ack_i || wb_err_i || timeout;
    fail = wb_err_i || (timeout && !wb_ack_i);
    state_d = state_q == IDLE ? (req_i ? BUS : IDLE)
            : in_bus ? (done ? RESP : BUS)
            : IDLE;
  end
  always_ff @(posedge clk_core or posedge rst_core)
    if (rst_core) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_o) begin
        addr_q  <= addr_i;
        we_q    <= we_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
      if (in_bus && done) begin
        rdata_q <= (fail || we_q) ? '0 : wb_data_i;
        err_q   <= fail;
      end
    end
  assign gnt_o     = req_i && state_q == IDLE;
  assign rvalid_o  = state_q == RESP;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = in_bus;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = be_q;
  assign wb_addr_o = addr_q & ~ADDR_WIDTH'(3);
  assign wb_data_o = wdata_q;
endmodule

// File: tb/tb_obi_wb_bridge.sv
// tb_obi_wb_bridge: directed stimulus with a response scoreboard checked by an rvalid monitor.
module tb_obi_wb_bridge;
  logic clk = 0, rst = 1;
  logic req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0, dat_i = 32'hBAD0BAD0;
  logic [3:0] be = 0;
  logic ack_drv = 0, err_drv = 0, auto_ack = 0;
  logic gnt_o, rvalid_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack;
  logic [31:0] rdata_o, wb_addr_o, wb_data_o;
  logic [3:0] wb_sel_o;
  typedef struct packed {logic [31:0] d; logic e;} resp_t;
  resp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign wb_ack = auto_ack ? wb_cyc_o : ack_drv;

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_core(clk), .rst_core(rst), .req_i(req), .gnt_o(gnt_o), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_data_i(dat_i), .wb_ack_i(wb_ack), .wb_err_i(err_drv)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && rvalid_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rvalid: got rdata %0h err %0b with no response pending", rdata_o, err_o);
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        if ({rdata_o, err_o} !== r) begin
          n_bad++;
          $display("FAIL response: got rdata %0h err %0b expected rdata %0h err %0b", rdata_o, err_o, r.d, r.e);
        end
      end
    end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input logic ack, input logic er,
                      input logic [31:0] erd, input logic ee);
    int n;
    @(negedge clk);
    req = 1; addr = a; we = w; be = b; wdata = wd;
    #1 n = 0;
    while (!gnt_o && n < 20) begin
      @(negedge clk); #1 n++;
    end
    chk("gnt", 64'(gnt_o), 1);
    exp_q.push_back('{erd, ee});
    @(posedge clk);
    #1 req = 0; addr = ~a; we = ~w; be = ~b; wdata = ~wd;
    for (int i = 0; i <= waits; i++) begin
      chk("cyc", 64'(wb_cyc_o), 1);
      chk("stb", 64'(wb_stb_o), 1);
      chk("wb_addr", 64'(wb_addr_o), 64'({a[31:2], 2'b00}));
      chk("wb_sel", 64'(wb_sel_o), 64'(b));
      chk("wb_data", 64'(wb_data_o), 64'(wd));
      chk("wb_we", 64'(wb_we_o), 64'(w));
      if (i == waits) begin
        ack_drv = ack; err_drv = er; dat_i = rd;
      end
      @(posedge clk); #1;
    end
    ack_drv = 0; err_drv = 0; dat_i = 32'hBAD0BAD0;
    chk("rvalid", 64'(rvalid_o), 1);
    chk("cyc_done", 64'(wb_cyc_o), 0);
    @(posedge clk);
    #1 chk("rvalid_once", 64'(rvalid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_cyc", 64'(wb_cyc_o), 0);
    chk("rst_rvalid", 64'(rvalid_o), 0);
    chk("rst_rdata", 64'(rdata_o), 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_addr", 64'(wb_addr_o), 0);
    chk("rst_sel", 64'(wb_sel_o), 0);
    rst = 0;
    xfer(32'h0000_1006, 0, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0);
    xfer(32'h0000_0020, 1, 4'b0011, 32'h12345678, 3, 32'hFFFF_FFFF, 1, 0, 32'h0, 0);
    xfer(32'h0000_0300, 0, 4'hF, 32'h0, 1, 32'h5555_AAAA, 1, 1, 32'h0, 1);
    xfer(32'h0000_000B, 0, 4'b1100, 32'h0, 2, 32'h0000_0001, 0, 1, 32'h0, 1);
    // back-to-back requests against a zero-wait slave
    @(negedge clk);
    auto_ack = 1; dat_i = 32'hA5A5_0000; req = 1; addr = 32'h44; we = 0; be = 4'hF;
    for (int i = 0; i < 9; i++) begin
      #1 chk("b2b_gnt", 64'(gnt_o), 64'(i % 3 == 0));
      if (gnt_o) exp_q.push_back('{32'hA5A5_0000, 1'b0});
      @(negedge clk);
    end
    req = 0;
    repeat (3) @(negedge clk);
    auto_ack = 0; dat_i = 32'hBAD0BAD0;
    // reset pulsed mid-BUS drops the transfer
    req = 1; addr = 32'h40; we = 0; be = 4'hF;
    #1 chk("rst_test_gnt", 64'(gnt_o), 1);
    @(posedge clk);
    #1 req = 0;
    chk("rst_test_cyc", 64'(wb_cyc_o), 1);
    @(posedge clk);
    #2 rst = 1;
    #1 chk("rst_mid_cyc", 64'(wb_cyc_o), 0);
    chk("rst_mid_rvalid", 64'(rvalid_o), 0);
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      @(negedge clk); #1 chk("rst_no_rvalid", 64'(rvalid_o), 0);
    end
    xfer(32'h0000_0104, 0, 4'hF, 32'h0, 0, 32'h0BAD_F00D, 1, 0, 32'h0BAD_F00D, 0);
    // slave that never answers
    @(negedge clk);
    req = 1; addr = 32'h200; we = 0; be = 4'hF;
    #1 chk("tmo_gnt", 64'(gnt_o), 1);
`ifdef BRIDGE_TIMEOUT_EN
    exp_q.push_back('{32'h0, 1'b1});
`else
    exp_q.push_back('{32'h7777_0000, 1'b0});
`endif
    @(posedge clk);
    #1 req = 0;
    n = 0;
`ifdef BRIDGE_TIMEOUT_EN
    while (wb_cyc_o && n < 50) begin
      n++; @(posedge clk); #1;
    end
    chk("tmo_cyc_cycles", 64'(n), 8);
    chk("tmo_rvalid", 64'(rvalid_o), 1);
    @(posedge clk);
    #1 chk("tmo_rvalid_once", 64'(rvalid_o), 0);
`else
    while (wb_cyc_o && n < 1000) begin
      n++; @(posedge clk); #1;
    end
    chk("no_tmo_cyc_cycles", 64'(n), 1000);
    chk("no_tmo_cyc_still", 64'(wb_cyc_o), 1);
    ack_drv = 1; dat_i = 32'h7777_0000;
    @(posedge clk);
    #1 ack_drv = 0;
    chk("no_tmo_rvalid", 64'(rvalid_o), 1);
    @(posedge clk);
    #1 dat_i = 32'hBAD0BAD0;
`endif
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
